tensor_load_sequencer: RTL and testbench

Controller that fills the 3x3 tensor register from data memory. On `start` it reads nine consecutive 16-bit words from `base_addr` onward and writes each into the tensor register through that register's `load`/`idx`/`element` write port, one element per write. It sits between the processor control unit, the memory read port and the tensor register, and it shares that register's clock and reset nets.

---
 rtl/tensor_pkg.sv | 13 +
 rtl/tensor_load_sequencer.sv | 102 ++++++++++
 tb/tb_tensor_load_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared tensor constants and load-sequencer state encoding
package tensor_pkg;

   localparam int TENSOR_ELEMS = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } tls_state_e;

endpackage

// File: rtl/tensor_load_sequencer.sv
// rtl/tensor_load_sequencer.sv - reads ELEMS consecutive words from memory into the tensor register
module tensor_load_sequencer
   import tensor_pkg::*;
#(
   parameter int ELEMS  = TENSOR_ELEMS,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              load,
   output logic [3:0]        idx,
   output logic [DATA_W-1:0] element,
   output logic              busy,
   output logic              done
);

   localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);

   tls_state_e        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] base_q;
   logic [DATA_W-1:0] elem_q;
   logic              req_q;
   logic              wr_q;
   logic              done_q;
   logic              busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         base_q <= '0;
         elem_q <= '0;
         req_q  <= 1'b0;
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  cnt    <= '0;
                  state  <= ST_REQ;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            ST_REQ: begin
               // abort outranks mem_ready, so the returned word is dropped
               if (abort) begin
                  state  <= ST_IDLE;
                  req_q  <= 1'b0;
                  busy_q <= 1'b0;
               end else if (mem_ready) begin
                  elem_q <= mem_rdata;
                  state  <= ST_WRITE;
                  req_q  <= 1'b0;
                  wr_q   <= 1'b1;
               end
            end
            ST_WRITE: begin
               wr_q <= 1'b0;
               if (abort) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == LAST_IDX) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end else begin
                  cnt   <= cnt + 4'd1;
                  state <= ST_REQ;
                  req_q <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req  = req_q;
   assign mem_addr = base_q + ADDR_W'(cnt);
   // the write strobe must vanish in the same cycle abort is raised
   assign load     = wr_q & ~abort;
   assign idx      = cnt;
   assign element  = elem_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_tensor_load_sequencer.sv
// tb/tb_tensor_load_sequencer.sv - scoreboard bench with memory responder and tensor register model
module tb_tensor_load_sequencer;

   localparam int ELEMS = 9;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  base_addr = '0;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        load;
   logic [3:0]  idx;
   logic [15:0] element;
   logic        busy;
   logic        done;

   tensor_load_sequencer #(.ELEMS(ELEMS), .ADDR_W(10), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .load(load), .idx(idx), .element(element), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  idx;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          exp_done = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          ncyc = 0;
   int          loads_seen = 0;
   int          dones_seen = 0;
   int          done_ncyc = 0;
   int          k_start = 0;
   logic [15:0] mem [1024];
   logic [15:0] treg [ELEMS];
   logic [15:0] treg_exp [ELEMS];
   logic [9:0]  addr_log[$];
   int          hold_len [16];
   int          wait_idx = -1;
   int          wait_n = 0;
   bit          rand_waits = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) ncyc <= ncyc + 1;

   always @(posedge clk) if (load) treg[idx] <= element;

   // memory responder: honours per-request wait counts, logs addresses and hold lengths
   initial begin
      bit in_req = 0;
      int target = 0;
      int waited = 0;
      forever begin
         @(negedge clk);
         if (mem_req && !reset) begin
            if (!in_req) begin
               in_req = 1;
               waited = 0;
               addr_log.push_back(mem_addr);
               target = rand_waits ? int'($urandom_range(0, 2)) : ((int'(idx) == wait_idx) ? wait_n : 0);
            end
            if (waited >= target) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr];
               hold_len[idx] = waited + 1;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               waited++;
            end
         end else begin
            in_req = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // monitor: pops the scoreboard on every load and done
   initial begin
      bit         prev_req = 0;
      logic [9:0] prev_addr = '0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (load) begin
               loads_seen++;
               if (exp_q.size() == 0) check("load_unexpected", 32'(idx), 32'hFFFF_FFFF);
               else begin
                  e = exp_q.pop_front();
                  check("load_idx", 32'(idx), 32'(e.idx));
                  check("load_element", 32'(element), 32'(e.data));
               end
            end
            if (done) begin
               dones_seen++;
               done_ncyc = ncyc;
               check("done_expected", 32'(exp_done > 0), 32'd1);
               if (exp_done > 0) exp_done--;
            end
            if (mem_req && prev_req) check("req_addr_stable", 32'(mem_addr), 32'(prev_addr));
            prev_req  = mem_req;
            prev_addr = mem_addr;
         end else prev_req = 0;
      end
   end

   task automatic push_expected(input logic [9:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         logic [9:0] a;
         a = b + 10'(i);
         exp_q.push_back('{idx: 4'(i), data: mem[a]});
         treg_exp[i] = mem[a];
      end
      if (n == ELEMS) exp_done++;
   endtask

   task automatic start_load(input logic [9:0] b);
      start = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = $urandom;
      k_start = ncyc;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_for_write(input int want);
      int n;
      n = 0;
      while (!(load && int'(idx) == want) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_write", 32'(load && int'(idx) == want), 32'd1);
   endtask

   task automatic check_treg(input string name);
      for (int i = 0; i < ELEMS; i++) check(name, 32'(treg[i]), 32'(treg_exp[i]));
   endtask

   initial begin
      int d0;
      int n;
      for (int a = 0; a < 1024; a++) mem[a] = 16'h1000 + 16'(a);
      for (int i = 0; i < ELEMS; i++) begin
         treg[i] = '0;
         treg_exp[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 32'({mem_req, load, busy, done}), 32'd0);
      check("reset_addr", 32'(mem_addr), 32'd0);
      check("reset_data", 32'({idx, element}), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // zero-wait load from 0x020
      push_expected(10'h020, ELEMS);
      start_load(10'h020);
      wait_idle("zero_wait_idle");
      check("zero_wait_done_time", 32'(done_ncyc - k_start), 32'(2 * ELEMS));
      check_treg("zero_wait_treg");

      // three wait cycles on element 4
      wait_idx = 4;
      wait_n = 3;
      push_expected(10'h020, ELEMS);
      start_load(10'h020);
      wait_idle("wait_idle");
      check("wait_done_time", 32'(done_ncyc - k_start), 32'(2 * ELEMS + 3));
      check("wait_hold_len", 32'(hold_len[4]), 32'd4);
      wait_idx = -1;

      // address wrap
      addr_log.delete();
      push_expected(10'h3FC, ELEMS);
      start_load(10'h3FC);
      wait_idle("wrap_idle");
      check("wrap_count", 32'(addr_log.size()), 32'(ELEMS));
      for (int i = 0; i < addr_log.size() && i < ELEMS; i++)
         check("wrap_addr", 32'(addr_log[i]), 32'((10'h3FC + i) & 10'h3FF));

      // abort in WRITE of idx 5
      for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
      push_expected(10'h100, 5);
      d0 = dones_seen;
      start_load(10'h100);
      wait_for_write(5);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 32'(dones_seen - d0), 32'd0);
      check_treg("abort_treg");

      // async reset mid-REQ of idx 2
      wait_idx = 2;
      wait_n = 10;
      push_expected(10'h200, 2);
      start_load(10'h200);
      n = 0;
      while (!(mem_req && idx == 4'd2) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("reset_reach_req2", 32'(mem_req && idx == 4'd2), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_ctrl", 32'({mem_req, load, busy, done}), 32'd0);
      check("async_reset_addr", 32'(mem_addr), 32'd0);
      check("async_reset_data", 32'({idx, element}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_idx = -1;
      push_expected(10'h200, ELEMS);
      start_load(10'h200);
      wait_idle("restart_idle");
      check_treg("restart_treg");

      // start pulsed while busy
      n = loads_seen;
      d0 = dones_seen;
      push_expected(10'h050, ELEMS);
      start_load(10'h050);
      repeat (5) @(posedge clk);
      #1;
      start_load(10'h2A0);
      wait_idle("busy_start_idle");
      check("busy_start_loads", 32'(loads_seen - n), 32'(ELEMS));
      check("busy_start_dones", 32'(dones_seen - d0), 32'd1);

      // randomized loads with random wait states
      rand_waits = 1;
      for (int t = 0; t < 6; t++) begin
         logic [9:0] b;
         for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
         b = 10'($urandom);
         d0 = dones_seen;
         push_expected(b, ELEMS);
         start_load(b);
         wait_idle("rand_idle");
         check("rand_done", 32'(dones_seen - d0), 32'd1);
         check_treg("rand_treg");
      end
      rand_waits = 0;

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("done_all_seen", 32'(exp_done), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
